// File: rtl/ex_mdu_pkg.sv
// Shared widths, opcodes and FSM encodings for the EX-stage multiply-accumulate/divide unit.
package ex_mdu_pkg;

   localparam int unsigned RegBus   = 32;
   localparam int unsigned AluOpBus = 8;

   localparam logic [AluOpBus-1:0] EXE_MADD_OP  = 8'b10100110;
   localparam logic [AluOpBus-1:0] EXE_MADDU_OP = 8'b10101000;
   localparam logic [AluOpBus-1:0] EXE_MSUB_OP  = 8'b10101010;
   localparam logic [AluOpBus-1:0] EXE_MSUBU_OP = 8'b10101011;
   localparam logic [AluOpBus-1:0] EXE_DIV_OP   = 8'b00011010;
   localparam logic [AluOpBus-1:0] EXE_DIVU_OP  = 8'b00011011;

   localparam logic DivResultReady = 1'b1;
   localparam logic DivStop        = 1'b0;

   typedef enum logic [2:0] {
      DivFree   = 3'd0,
      DivMacc   = 3'd1,
      DivByZero = 3'd2,
      DivOn     = 3'd3,
      DivEnd    = 3'd4
   } mdu_state_e;

   function automatic logic [RegBus-1:0] abs32(input logic [RegBus-1:0] v, input logic sgn);
      return (sgn && v[RegBus-1]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_div.sv
// 32-iteration restoring divider: magnitudes are divided, signs are fixed up on the way out.
module mdu_div
   import ex_mdu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                signed_div_i,
   input  logic [RegBus-1:0]   opdata1_i,
   input  logic [RegBus-1:0]   opdata2_i,
   input  logic                annul_i,
   output logic [2*RegBus-1:0] result_o,
   output logic                ready_o
);

   // work_q = {partial remainder, remaining dividend bits / quotient bits, newest quotient bit}
   logic [64:0] work_q, work_d;
   logic [31:0] divisor_q, divisor_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        run_q, run_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;

   logic [32:0] trial;
   logic        ge;
   logic [31:0] rem_next;
   logic [31:0] quo, rem;

   always_comb begin
      trial    = work_q[64:32];
      ge       = (trial >= {1'b0, divisor_q});
      // When ge holds the true difference is below the divisor, so 32 bits suffice.
      rem_next = ge ? (trial[31:0] - divisor_q) : trial[31:0];
   end

   always_comb begin
      work_d    = work_q;
      divisor_d = divisor_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (annul_i) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start_i) begin
         divisor_d = abs32(opdata2_i, signed_div_i);
         work_d    = (opdata2_i == '0) ? '0 : {32'b0, abs32(opdata1_i, signed_div_i), 1'b0};
         cnt_d     = '0;
         run_d     = (opdata2_i != '0);
         neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
         neg_rem_d = signed_div_i & opdata1_i[31];
      end else if (run_q) begin
         work_d = {rem_next, work_q[31:0], ge};
         cnt_d  = cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         work_q    <= '0;
         divisor_q <= '0;
         cnt_q     <= '0;
         run_q     <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         work_q    <= work_d;
         divisor_q <= divisor_d;
         cnt_q     <= cnt_d;
         run_q     <= run_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   always_comb begin
      quo      = neg_quo_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
      rem      = neg_rem_q ? (~work_q[64:33] + 32'd1) : work_q[64:33];
      result_o = {rem, quo};
      ready_o  = (run_q && (cnt_q == 5'd31) && !annul_i) ? DivResultReady : DivStop;
   end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multi-cycle unit: 2-cycle MADD/MSUB family and 34-cycle DIV/DIVU with stall request.
module ex_mdu
   import ex_mdu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [AluOpBus-1:0] aluop_i,
   input  logic [RegBus-1:0]   reg1_i,
   input  logic [RegBus-1:0]   reg2_i,
   input  logic [RegBus-1:0]   hi_i,
   input  logic [RegBus-1:0]   lo_i,
   input  logic                annul_i,
   output logic [2*RegBus-1:0] hilo_o,
   output logic                whilo_o,
   output logic                stallreq_o
);

   mdu_state_e  state_q, state_d;
   logic [63:0] prod_q, prod_d;
   logic        sub_q, sub_d;
   logic        div_q, div_d;

   logic        is_macc, is_div, mul_signed, mul_sub, div_signed;
   logic [63:0] prod_s, prod_u, prod;
   logic        div_start, div_ready;
   logic [63:0] div_result;

   always_comb begin
      is_macc    = 1'b0;
      is_div     = 1'b0;
      mul_signed = 1'b0;
      mul_sub    = 1'b0;
      div_signed = 1'b0;
      case (aluop_i)
         EXE_MADD_OP:  begin is_macc = 1'b1; mul_signed = 1'b1; end
         EXE_MADDU_OP: is_macc = 1'b1;
         EXE_MSUB_OP:  begin is_macc = 1'b1; mul_signed = 1'b1; mul_sub = 1'b1; end
         EXE_MSUBU_OP: begin is_macc = 1'b1; mul_sub = 1'b1; end
         EXE_DIV_OP:   begin is_div = 1'b1; div_signed = 1'b1; end
         EXE_DIVU_OP:  is_div = 1'b1;
         default:      ;
      endcase
   end

   always_comb begin
      prod_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
      prod_u = {32'b0, reg1_i} * {32'b0, reg2_i};
      prod   = mul_signed ? prod_s : prod_u;
   end

   assign div_start = (state_q == DivFree) && is_div && !annul_i;

   mdu_div u_div (
      .clk          (clk),
      .rst          (rst),
      .start_i      (div_start),
      .signed_div_i (div_signed),
      .opdata1_i    (reg1_i),
      .opdata2_i    (reg2_i),
      .annul_i      (annul_i),
      .result_o     (div_result),
      .ready_o      (div_ready)
   );

   // Operation context is captured only when an op is accepted in FREE.
   always_comb begin
      prod_d = prod_q;
      sub_d  = sub_q;
      div_d  = div_q;
      if ((state_q == DivFree) && !annul_i && (is_macc || is_div)) begin
         prod_d = is_macc ? prod : '0;
         sub_d  = mul_sub;
         div_d  = is_div;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DivFree;
         prod_q  <= '0;
         sub_q   <= 1'b0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prod_q  <= prod_d;
         sub_q   <= sub_d;
         div_q   <= div_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (annul_i) begin
         state_d = DivFree;
      end else begin
         unique case (state_q)
            DivFree: begin
               if (is_macc) begin
                  state_d = DivMacc;
               end else if (is_div) begin
                  state_d = (reg2_i == '0) ? DivByZero : DivOn;
               end
            end
            DivMacc:   state_d = DivEnd;
            DivByZero: state_d = DivEnd;
            DivOn:     if (div_ready == DivResultReady) state_d = DivEnd;
            DivEnd:    state_d = DivFree;
            default:   state_d = DivFree;
         endcase
      end
   end

   always_comb begin
      hilo_o     = '0;
      whilo_o    = 1'b0;
      stallreq_o = 1'b0;
      if (!rst && !annul_i) begin
         unique case (state_q)
            DivFree: stallreq_o = is_macc | is_div;
            DivMacc: begin
               hilo_o  = sub_q ? ({hi_i, lo_i} - prod_q) : ({hi_i, lo_i} + prod_q);
               whilo_o = 1'b1;
            end
            DivByZero, DivOn: stallreq_o = 1'b1;
            DivEnd: begin
               // MACC ops already wrote in DivMacc.
               if (div_q) begin
                  hilo_o  = div_result;
                  whilo_o = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed and lightly randomised bench for ex_mdu with an expected-result queue.
module tb_ex_mdu;
   import ex_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop;
   logic [31:0] reg1, reg2, hi, lo;
   logic        annul;
   logic [63:0] hilo;
   logic        whilo, stallreq;

   logic [63:0] exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   localparam logic [7:0] NOP = 8'h00;

   ex_mdu dut (
      .clk        (clk),
      .rst        (rst),
      .aluop_i    (aluop),
      .reg1_i     (reg1),
      .reg2_i     (reg2),
      .hi_i       (hi),
      .lo_i       (lo),
      .annul_i    (annul),
      .hilo_o     (hilo),
      .whilo_o    (whilo),
      .stallreq_o (stallreq)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0b want %0b", tag, got, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %016h want %016h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk1({tag, " idle stall"}, stallreq, 1'b0);
      chk1({tag, " idle whilo"}, whilo, 1'b0);
      chk64({tag, " idle hilo"}, hilo, 64'h0);
   endtask

   // Called at cycle 0 (just after a rising edge); returns one cycle after the idle check.
   task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                         input logic [63:0] exp, input int wc);
      aluop = op; reg1 = a; reg2 = b; hi = h; lo = l;
      exp_q.push_back(exp);
      for (int c = 0; c <= wc; c++) begin
         #4;
         chk1($sformatf("%s stall c%0d", tag, c), stallreq, c < wc);
         chk1($sformatf("%s whilo c%0d", tag, c), whilo, c == wc);
         if (c == wc || whilo === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk1({tag, " unexpected write"}, whilo, 1'b0);
            end else begin
               chk64({tag, " hilo"}, hilo, exp_q.pop_front());
            end
         end
         next_cycle();
      end
      aluop = NOP;
      #4;
      chk_idle(tag);
      next_cycle();
   endtask

   function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
      logic signed [31:0] sa, sb;
      logic [31:0] q, r;
      sa = a;
      sb = b;
      if (b == 32'h0) return 64'h0;
      if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   function automatic logic [63:0] macc_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] h, input logic [31:0] l,
                                              input logic sgn, input logic sub);
      logic signed [63:0] pa, pb;
      logic [63:0] p;
      if (sgn) begin
         pa = {{32{a[31]}}, a};
         pb = {{32{b[31]}}, b};
         p  = pa * pb;
      end else begin
         p = {32'h0, a} * {32'h0, b};
      end
      return sub ? ({h, l} - p) : ({h, l} + p);
   endfunction

   initial begin
      logic [31:0] ra, rb, rh, rl;
      rst = 1'b1; aluop = EXE_DIV_OP; reg1 = 32'd9; reg2 = 32'd3; hi = '0; lo = '0; annul = 1'b0;
      next_cycle();
      next_cycle();
      #4;
      chk_idle("reset held");
      next_cycle();
      rst = 1'b0; aluop = NOP;
      #4;
      chk_idle("after reset");
      next_cycle();

      // Divides
      run_op("divu 100/7", EXE_DIVU_OP, 32'd100, 32'd7, 0, 0, {32'd2, 32'd14}, 33);
      run_op("div -7/2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 0, 0,
             {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      run_op("div min/-1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
             {32'h0, 32'h8000_0000}, 33);
      run_op("div 5/0", EXE_DIV_OP, 32'd5, 32'd0, 0, 0, 64'h0, 2);
      run_op("divu big", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0,
             {32'h7FFF_FFFE, 32'h1}, 33);

      // Multiply-accumulate
      run_op("madd 3*4+5", EXE_MADD_OP, 32'd3, 32'd4, 32'd0, 32'd5, 64'h11, 1);
      run_op("msubu 1*1", EXE_MSUBU_OP, 32'd1, 32'd1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_op("maddu ff*ff+1", EXE_MADDU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1,
             64'hFFFF_FFFE_0000_0002, 1);
      run_op("msub -2*3", EXE_MSUB_OP, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 64'd6, 1);

      // Back-to-back MADD; second sum uses the forwarded first result
      aluop = EXE_MADD_OP; reg1 = 32'd3; reg2 = 32'd4; hi = 32'd0; lo = 32'd5;
      #4; chk1("b2b c0 stall", stallreq, 1'b1);
      next_cycle();
      #4; chk1("b2b c1 whilo", whilo, 1'b1); chk64("b2b c1 hilo", hilo, 64'h11);
      next_cycle();
      #4; chk1("b2b c2 whilo", whilo, 1'b0); chk1("b2b c2 stall", stallreq, 1'b0);
      next_cycle();
      #4; chk1("b2b c3 stall", stallreq, 1'b1); chk1("b2b c3 whilo", whilo, 1'b0);
      next_cycle();
      hi = 32'd0; lo = 32'h11;
      #4; chk1("b2b c4 whilo", whilo, 1'b1); chk64("b2b c4 hilo", hilo, 64'h1D);
      next_cycle();
      aluop = NOP; hi = '0; lo = '0;
      #4; chk_idle("b2b end");
      next_cycle();

      // Unknown opcode does nothing
      aluop = 8'h20; reg1 = 32'd1; reg2 = 32'd0;
      for (int i = 0; i < 3; i++) begin
         #4; chk_idle("unknown op");
         next_cycle();
      end
      aluop = NOP;

      // Annul in cycle 10 of a DIV, then restart from FREE
      aluop = EXE_DIV_OP; reg1 = 32'd100; reg2 = 32'd7;
      for (int c = 0; c < 10; c++) begin
         #4; chk1($sformatf("annul pre c%0d stall", c), stallreq, 1'b1);
         next_cycle();
      end
      annul = 1'b1;
      #4; chk1("annul c10 stall", stallreq, 1'b0); chk1("annul c10 whilo", whilo, 1'b0);
      next_cycle();
      annul = 1'b0;
      run_op("div after annul", EXE_DIV_OP, 32'd100, 32'd7, 0, 0, {32'd2, 32'd14}, 33);

      // Synchronous reset mid-DIV
      aluop = EXE_DIVU_OP; reg1 = 32'd1000; reg2 = 32'd3;
      for (int c = 0; c < 5; c++) begin
         #4; chk1($sformatf("rst pre c%0d stall", c), stallreq, 1'b1);
         next_cycle();
      end
      rst = 1'b1;
      #4; chk_idle("rst asserted");
      next_cycle();
      rst = 1'b0; aluop = NOP;
      #4; chk_idle("rst next cycle");
      next_cycle();
      run_op("divu after rst", EXE_DIVU_OP, 32'd1000, 32'd3, 0, 0, {32'd1, 32'd333}, 33);

      // Randomised vectors against the reference models
      for (int i = 0; i < 4; i++) begin
         ra = $urandom; rb = $urandom;
         if (i == 3) rb = rb >> 20;
         run_op($sformatf("rand div %0d", i), EXE_DIV_OP, ra, rb, 0, 0,
                div_model(ra, rb, 1'b1), (rb == 0) ? 2 : 33);
         run_op($sformatf("rand divu %0d", i), EXE_DIVU_OP, ra, rb, 0, 0,
                div_model(ra, rb, 1'b0), (rb == 0) ? 2 : 33);
      end
      for (int i = 0; i < 4; i++) begin
         ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
         run_op($sformatf("rand madd %0d", i), EXE_MADD_OP, ra, rb, rh, rl,
                macc_model(ra, rb, rh, rl, 1'b1, 1'b0), 1);
         run_op($sformatf("rand msubu %0d", i), EXE_MSUBU_OP, ra, rb, rh, rl,
                macc_model(ra, rb, rh, rl, 1'b0, 1'b1), 1);
      end

      n_vec++;
      assert (exp_q.size() == 0) else begin
         n_err++;
         $error("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Multi-cycle multiply-accumulate and divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the ALU opcode and both operands latched by ID/EX. It executes MADD/MADDU/MSUB/MSUBU in 2 cycles and DIV/DIVU in 34 cycles. While busy it raises a stall request so ID/EX holds its outputs stable. On completion it presents a 64-bit HI/LO write for the EX/MEM register.

## Interface
- No parameters; all widths come from the shared defines (RegBus = 32, AluOpBus = 8).
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- aluop_i  in  8  opcode from ID/EX (ex_aluop)
- reg1_i  in  32  operand rs / dividend
- reg2_i  in  32  operand rt / divisor
- hi_i  in  32  current HI, already forwarded from MEM/WB
- lo_i  in  32  current LO, already forwarded from MEM/WB
- annul_i  in  1  flush; aborts any operation in progress
- hilo_o  out  64  result {HI, LO}
- whilo_o  out  1  HI/LO write enable, valid for exactly one cycle
- stallreq_o  out  1  stall request to the pipeline controller

## Operation
- Opcodes handled:
  - EXE_MADD_OP = 8'b10100110
  - EXE_MADDU_OP = 8'b10101000
  - EXE_MSUB_OP = 8'b10101010
  - EXE_MSUBU_OP = 8'b10101011
  - EXE_DIV_OP = 8'b00011010
  - EXE_DIVU_OP = 8'b00011011
- Any other opcode: outputs stay 0 and the FSM stays in FREE.
- FSM states: FREE, MACC, BYZERO, DIVON, END.
- MADD/MADDU/MSUB/MSUBU:
  - FREE: register the 64-bit product, signed or unsigned per opcode. Go to MACC. stallreq_o = 1.
  - MACC: compute hilo_o = {hi_i, lo_i} + product (MADD/MADDU) or − product (MSUB/MSUBU), modulo 2^64. Assert whilo_o = 1 and stallreq_o = 0. Go to END.
- DIV/DIVU, divisor nonzero:
  - FREE: for DIV, load the absolute values of both operands. Clear the iteration count. Go to DIVON. stallreq_o = 1.
  - DIVON: 32 restoring shift-subtract iterations, one per cycle, on a 65-bit working register. stallreq_o = 1.
  - After the 32nd iteration, go to END.
- DIV/DIVU, divisor == 0:
  - FREE: go to BYZERO. stallreq_o = 1.
  - BYZERO: result = 0. Go to END. stallreq_o = 1.
- END:
  - hilo_o = {remainder, quotient}; whilo_o = 1; stallreq_o = 0.
  - For MACC ops, END holds whilo_o = 0. Their write was issued in MACC.
  - END always goes to FREE. The instruction presented next cycle is new, so back-to-back identical ops restart cleanly.
- DIV sign fixup:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - −2^31 / −1 gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- annul_i = 1 in any state: next state FREE. In that same cycle whilo_o = 0 and stallreq_o = 0.
- rst = 1: state FREE, all internal registers 0; hilo_o = 0, whilo_o = 0, stallreq_o = 0.

## Timing
- Cycle 0 is the first cycle the opcode is visible on aluop_i.
- MACC ops: stallreq_o is high in cycle 0 only. whilo_o and the result come in cycle 1.
- DIV, nonzero divisor:
  - stallreq_o is high in cycles 0–32.
  - Cycle 33 is END: whilo_o = 1, result valid, stallreq_o = 0.
- DIV by zero: stallreq_o is high in cycles 0–1. Cycle 2 is END with result 0.
- hi_i and lo_i are sampled only in MACC. A HI/LO write that is still in MEM/WB is therefore included.
- Operands are sampled only in FREE. Changes to the inputs during DIVON are ignored.
- Outputs are combinational from the state and working registers. All state changes on the rising edge of clk.

## Structure
- Add to the shared define file:
  - the six opcode constants above
  - FSM state encodings DivFree, DivMacc, DivByZero, DivOn, DivEnd
  - the constants DivResultReady and DivStop
- Sub-module mdu_div contains the 32-iteration divider datapath and counter.
  - Inputs: start, signed_div, opdata1, opdata2, annul.
  - Outputs: result[63:0], ready.
- ex_mdu holds the opcode decode, the MACC path, and the top-level FSM.

## Test plan
- DIVU 100 / 7: stallreq_o high in cycles 0–32. Cycle 33: whilo_o = 1, hilo_o = {32'd2, 32'd14}.
- DIV 0xFFFFFFF9 (−7) / 2 at END: hilo_o = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000 / 0xFFFFFFFF at END: hilo_o = {0, 0x80000000}.
- DIV 5 / 0: stallreq_o high in cycles 0–1. Cycle 2: whilo_o = 1, hilo_o = 0.
- MADD 3, 4 with hi_i = 0, lo_i = 5: cycle 1 whilo_o = 1, hilo_o = 0x0000_0000_0000_0011. MSUBU 1, 1 with HI/LO = 0: hilo_o = 0xFFFF_FFFF_FFFF_FFFF.
- Back-to-back MADD, MADD:
  - First op writes in cycle 1. Second op stalls in cycle 3 and writes in cycle 4.
  - Bench drives hi_i/lo_i with the first result in cycle 4: the second sum must include it.
- annul_i pulsed in cycle 10 of a DIV:
  - Cycle 10: whilo_o = 0 and stallreq_o = 0. Cycle 11: state FREE.
  - Repeat the run with rst asserted mid-DIV: all outputs 0 on the next cycle, and a new DIVU completes correctly afterwards.
